// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor: SEG_W bits rippled per stage, carry registered between stages.
// Optional signed-overflow flag enabled by defining RCA_OVF_DETECT_EN (otherwise ovf is tied low).
module rca_pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG_SAFE = (SEG_W < 1) ? 1 : SEG_W;
  localparam int STAGES   = WIDTH / SEG_SAFE;
  localparam int LAST     = STAGES - 1;

  if ((SEG_W < 1) || ((WIDTH % SEG_SAFE) != 0)) begin : g_bad_cfg
    $error("rca_pipe_addsub: WIDTH must be a positive multiple of SEG_W");
  end

  logic                stall;
  logic                en;
  logic [STAGES-1:0]   v_q, v_d;
  logic [STAGES-1:0]   c_q, c_d;
  logic [WIDTH-1:0]    a_q [STAGES];
  logic [WIDTH-1:0]    a_d [STAGES];
  logic [WIDTH-1:0]    b_q [STAGES];
  logic [WIDTH-1:0]    b_d [STAGES];
  logic [WIDTH-1:0]    s_q [STAGES];
  logic [WIDTH-1:0]    s_d [STAGES];
  logic [STAGES-1:0]   src_v, src_c;
  logic [WIDTH-1:0]    src_a [STAGES];
  logic [WIDTH-1:0]    src_b [STAGES];
  logic [WIDTH-1:0]    src_s [STAGES];
  logic [SEG_W:0]      seg;

  // A stall (result held, downstream not ready) freezes the entire pipeline.
  assign stall    = v_q[LAST] & ~out_ready;
  assign en       = ~stall;
  assign in_ready = ~stall;

  // Stage 0 takes the inverted operand and carry for subtraction; later stages read the previous register.
  assign src_a[0] = in0;
  assign src_b[0] = sub ? ~in1 : in1;
  assign src_c[0] = sub ? ~cin : cin;
  assign src_v[0] = in_valid;
  assign src_s[0] = '0;

  for (genvar k = 1; k < STAGES; k++) begin : g_chain
    assign src_a[k] = a_q[k-1];
    assign src_b[k] = b_q[k-1];
    assign src_c[k] = c_q[k-1];
    assign src_v[k] = v_q[k-1];
    assign src_s[k] = s_q[k-1];
  end

  always_comb begin
    seg = '0;
    for (int k = 0; k < STAGES; k++) begin
      seg = {1'b0, src_a[k][k*SEG_W +: SEG_W]}
          + {1'b0, src_b[k][k*SEG_W +: SEG_W]}
          + {{SEG_W{1'b0}}, src_c[k]};
      a_d[k] = src_a[k];
      b_d[k] = src_b[k];
      s_d[k] = src_s[k];
      s_d[k][k*SEG_W +: SEG_W] = seg[SEG_W-1:0];
      c_d[k] = seg[SEG_W];
      v_d[k] = src_v[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (en) begin
      v_q <= v_d;
      c_q <= c_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
    end
  end

  assign out       = s_q[LAST];
  assign cout      = c_q[LAST];
  assign out_valid = v_q[LAST];

`ifdef RCA_OVF_DETECT_EN
  logic ovf_q, ovf_d;

  // Same-sign operands producing an opposite-sign result overflow the signed range.
  assign ovf_d = (a_d[LAST][WIDTH-1] == b_d[LAST][WIDTH-1]) &
                 (s_d[LAST][WIDTH-1] != a_d[LAST][WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// Scoreboard bench for rca_pipe_addsub: driver pushes reference results, a monitor pops and compares.
module tb_rca_pipe_addsub;
  localparam int W  = 32;
  localparam int SG = 8;
  localparam int ST = W / SG;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          cin = 1'b0;
  logic          sub = 1'b0;
  logic          out_ready = 1'b1;
  logic [W-1:0]  in0 = '0;
  logic [W-1:0]  in1 = '0;
  logic          in_ready, out_valid, cout, ovf;
  logic [W-1:0]  out;

  typedef struct packed { logic [W-1:0] o; logic c; logic v; } exp_t;
  exp_t q[$];
  int   n_checks = 0;
  int   n_err = 0;
  logic done_rand = 1'b0;

  rca_pipe_addsub #(.WIDTH(W), .SEG_W(SG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the true mathematical values.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic s);
    longint unsigned ua, ub, t;
    longint          sa, sb, r;
    exp_t            e;
    ua = a; ub = b;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    if (!s) begin
      t   = ua + ub + c;
      e.o = t[W-1:0];
      e.c = t[W];
      r   = sa + sb + c;
    end else begin
      t   = ua - ub - c;
      e.o = t[W-1:0];
      e.c = (ua >= ub + c);
      r   = sa - sb - c;
    end
`ifdef RCA_OVF_DETECT_EN
    e.v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
`else
    e.v = (r != r);
`endif
    return e;
  endfunction

  // Scoreboard push on every accepted beat; reset discards everything in flight.
  always @(negedge clk) begin
    if (rst) q.delete();
    else if (in_valid && in_ready) q.push_back(model(in0, in1, cin, sub));
  end

  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_o;
  logic         prev_c, prev_v;

  // Monitor: compare on handshake, check hold stability and the ready rule.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (prev_hold) begin
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_out", {31'd0, out, cout}, {31'd0, prev_o, prev_c});
        chk("hold_ovf", {63'd0, ovf}, {63'd0, prev_v});
      end
      chk("in_ready_rule", {63'd0, in_ready}, {63'd0, ~(out_valid & ~out_ready)});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", {31'd0, out, cout}, 64'hDEAD_BEEF_DEAD_BEEF);
        end else begin
          e = q.pop_front();
          chk("out", {32'd0, out}, {32'd0, e.o});
          chk("cout", {63'd0, cout}, {63'd0, e.c});
          chk("ovf", {63'd0, ovf}, {63'd0, e.v});
        end
      end
      prev_hold = out_valid & ~out_ready;
    end else begin
      prev_hold = 1'b0;
    end
    prev_o = out; prev_c = cout; prev_v = ovf;
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
    bit ok = 0;
    in0 = a; in1 = b; cin = c; sub = s; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (q.size() == 0 && !out_valid) begin ok = 1; break; end
    end
    chk("drain", {63'd0, ok}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {30'd0, out_valid, cout, ovf, in_ready}, 64'd1);
    chk("reset_out", {32'd0, out}, 64'd0);
    @(posedge clk); #1;

    // Directed arithmetic cases, including the segment-crossing latency check.
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'd5, 32'd7, 1'b0, 1'b1);
    send(32'd7, 32'd5, 1'b1, 1'b1);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    send(32'd3, 32'd4, 1'b0, 1'b0);
    drain();
    send(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    for (int i = 1; i <= ST; i++) begin
      @(negedge clk);
      chk($sformatf("latency_c%0d", i), {63'd0, out_valid}, {63'd0, (i == ST)});
    end
    drain();

    // Back-to-back beats with downstream stalled on cycles 5..7.
    fork
      for (int i = 0; i < 6; i++) send(W'(i + 16'h10), W'(i), 1'b0, 1'b0);
      for (int c = 0; c < 20; c++) begin
        out_ready = !(c >= 5 && c <= 7);
        @(posedge clk); #1;
      end
    join
    drain();

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom), 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_flush_valid", {63'd0, out_valid}, 64'd0);
    repeat (2 * ST) @(posedge clk);
    #1;

    // Random beats, bubbles and backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        done_rand = 1'b1;
      end
      while (!done_rand) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
    join
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
